mem_stage: RTL

//  MEM stage of the 5-stage pipeline: consumes the EX/MEM register outputs, performs byte/half/word

---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/mem_stage_ram.sv | 61 ++++++
 rtl/mem_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage slice.
//   mem_size_e    : EX/MEM access-size encodings
//   mem_wb_t      : MEM/WB register contents
//   MEM_WB_BUBBLE : value loaded into MEM/WB on reset or flush
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rf_enable;
    logic        hi_enable;
    logic        lo_enable;
    logic        align_fault;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_ram.sv
// Big-endian byte-addressed data RAM with sized access.
//   clk   : write clock, rising edge
//   we    : write enable (already qualified by caller)
//   size  : access size (mem_size_e encoding)
//   addr  : byte address; addr+1..addr+3 wrap modulo depth
//   wdata : store data, low-order bytes used for byte/half
//   rdata : asynchronous read, zero-filled above the accessed width
// Contents are never reset; the array is named Mem for external preload.
module data_ram
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [7:0] Mem [0:(2**ADDR_W)-1];

  logic [ADDR_W-1:0] a1, a2, a3;
  mem_size_e         sz;

  assign sz = mem_size_e'(size);
  assign a1 = addr + ADDR_W'(1);
  assign a2 = addr + ADDR_W'(2);
  assign a3 = addr + ADDR_W'(3);

  always_ff @(posedge clk) begin
    if (we) begin
      case (sz)
        SZ_BYTE: Mem[addr] <= wdata[7:0];
        SZ_HALF: begin
          Mem[addr] <= wdata[15:8];
          Mem[a1]   <= wdata[7:0];
        end
        SZ_WORD: begin
          Mem[addr] <= wdata[31:24];
          Mem[a1]   <= wdata[23:16];
          Mem[a2]   <= wdata[15:8];
          Mem[a3]   <= wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (sz)
      SZ_BYTE: rdata = {24'h0, Mem[addr]};
      SZ_HALF: rdata = {16'h0, Mem[addr], Mem[a1]};
      SZ_WORD: rdata = {Mem[addr], Mem[a1], Mem[a2], Mem[a3]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data RAM access, alignment check, load extension and the
// MEM/WB pipeline register.
//   clk, reset            : clock (rising) / async active-low reset
//   mem_enable, mem_rw    : RAM access request, 1 = store
//   mem_size, mem_se      : access size, sign-extend loads
//   load_instr            : write back RAM data instead of alu_result
//   rf/hi/lo_enable, rd   : write-back controls passed to MEM/WB
//   alu_result            : effective address / ALU result
//   store_data            : store value
//   stall, flush          : hold MEM/WB / load bubble (flush wins); both block stores
//   wb_*                  : MEM/WB outputs to write-back
//   align_fault           : registered flag for a misaligned/reserved access
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable,
  input  logic        mem_rw,
  input  logic [1:0]  mem_size,
  input  logic        mem_se,
  input  logic        load_instr,
  input  logic        rf_enable,
  input  logic        hi_enable,
  input  logic        lo_enable,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_rf_enable,
  output logic        wb_hi_enable,
  output logic        wb_lo_enable,
  output logic        align_fault
);

  mem_size_e         sz;
  logic [ADDR_W-1:0] addr;
  logic              fault;
  logic              ram_we;
  logic [31:0]       ram_rdata;
  logic [31:0]       load_ext;
  mem_wb_t           wb_d, wb_q;

  assign sz   = mem_size_e'(mem_size);
  assign addr = alu_result[ADDR_W-1:0];

  always_comb begin
    fault = 1'b0;
    if (mem_enable) begin
      case (sz)
        SZ_HALF: fault = addr[0];
        SZ_WORD: fault = (addr[1:0] != 2'b00);
        SZ_RSVD: fault = 1'b1;
        default: fault = 1'b0;
      endcase
    end
  end

  // reset is folded in so a store presented during reset never commits
  assign ram_we = mem_enable & mem_rw & ~fault & ~stall & ~flush & reset;

  data_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .size  (mem_size),
    .addr  (addr),
    .wdata (store_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    load_ext = ram_rdata;
    case (sz)
      SZ_BYTE: load_ext = {{24{mem_se & ram_rdata[7]}}, ram_rdata[7:0]};
      SZ_HALF: load_ext = {{16{mem_se & ram_rdata[15]}}, ram_rdata[15:0]};
      default: load_ext = ram_rdata;
    endcase
  end

  always_comb begin
    wb_d             = MEM_WB_BUBBLE;
    wb_d.rd          = rd;
    wb_d.hi_enable   = hi_enable;
    wb_d.lo_enable   = lo_enable;
    wb_d.align_fault = fault;
    wb_d.rf_enable   = rf_enable & ~fault;
    if (fault)
      wb_d.data = '0;
    else if (mem_enable && load_instr)
      wb_d.data = load_ext;
    else
      wb_d.data = alu_result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wb_q <= MEM_WB_BUBBLE;
    else if (flush)
      wb_q <= MEM_WB_BUBBLE;
    else if (!stall)
      wb_q <= wb_d;
  end

  assign wb_data      = wb_q.data;
  assign wb_rd        = wb_q.rd;
  assign wb_rf_enable = wb_q.rf_enable;
  assign wb_hi_enable = wb_q.hi_enable;
  assign wb_lo_enable = wb_q.lo_enable;
  assign align_fault  = wb_q.align_fault;

endmodule
